// File: rtl/regfile_pkg.sv
// Shared sizes and types for the eight-entry register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_dec.sv
// One-hot write decoder: turns a register index into per-register load enables.
// The enable input gates the whole vector, so at most one bit is ever set.
module regfile_dec
  import regfile_pkg::*;
(
  input  logic                en_i,
  input  reg_idx_t            addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // Set the addressed bit only when enabled; all other bits stay low.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule : regfile_dec

// File: rtl/regfile.sv
// Eight-entry, 16-bit register file: one synchronous write port and one
// combinational read port.
// Optional build macro REGFILE_BYPASS_EN: when defined, a write to the index
// being read is forwarded to data_out in the same cycle.
module regfile
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  word_t    data_in,
  input  reg_idx_t writenum,
  input  logic     write,
  input  reg_idx_t readnum,
  output word_t    data_out
);

  // Upper-case names are kept so the registers can be probed hierarchically.
  word_t R0, R1, R2, R3, R4, R5, R6, R7;

  logic [NUM_REGS-1:0] load;
  word_t               stored;

  regfile_dec u_dec (
    .en_i     (write),
    .addr_i   (writenum),
    .onehot_o (load)
  );

  // Register storage; reset clears everything and wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R0 <= '0;
      R1 <= '0;
      R2 <= '0;
      R3 <= '0;
      R4 <= '0;
      R5 <= '0;
      R6 <= '0;
      R7 <= '0;
    end else begin
      if (load[0]) R0 <= data_in;
      if (load[1]) R1 <= data_in;
      if (load[2]) R2 <= data_in;
      if (load[3]) R3 <= data_in;
      if (load[4]) R4 <= data_in;
      if (load[5]) R5 <= data_in;
      if (load[6]) R6 <= data_in;
      if (load[7]) R7 <= data_in;
    end
  end

  // Combinational read mux; every index 0..7 is legal.
  always_comb begin
    stored = R0;
    case (readnum)
      3'd0: stored = R0;
      3'd1: stored = R1;
      3'd2: stored = R2;
      3'd3: stored = R3;
      3'd4: stored = R4;
      3'd5: stored = R5;
      3'd6: stored = R6;
      3'd7: stored = R7;
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through: forward the incoming word when it targets the read index.
  assign data_out = (write && rst_n && (writenum == readnum)) ? data_in : stored;
`else
  assign data_out = stored;
`endif

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed steps followed by random traffic,
// all compared against a simple array model of the register file.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic [15:0] data_out;

  logic [15:0] model [8];
  int          vectors;
  int          miscompares;

  regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .writenum (writenum),
    .write    (write),
    .readnum  (readnum),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] probe(input int i);
    case (i)
      0: return dut.R0;
      1: return dut.R1;
      2: return dut.R2;
      3: return dut.R3;
      4: return dut.R4;
      5: return dut.R5;
      6: return dut.R6;
      default: return dut.R7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected data_out for the current (pre-edge) inputs.
  function automatic logic [15:0] expect_read();
`ifdef REGFILE_BYPASS_EN
    if (write && rst_n && writenum == readnum) return data_in;
`endif
    return model[readnum];
  endfunction

  // Apply one clock edge and update the model from the inputs that were present.
  task automatic tick();
    logic        r;
    logic        w;
    logic [2:0]  wn;
    logic [15:0] d;
    r  = rst_n;
    w  = write;
    wn = writenum;
    d  = data_in;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (w) begin
      model[wn] = d;
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_R%0d", tag, i), probe(i), model[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    write       = 1'b0;
    writenum    = 3'd0;
    readnum     = 3'd0;
    data_in     = 16'h0000;
    for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
    #2;

    // Reset for one edge, then sweep every read index.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      readnum = 3'(i);
      #1;
      check($sformatf("reset_read%0d", i), data_out, 16'h0000);
      check($sformatf("reset_R%0d", i), probe(i), 16'h0000);
    end

    // Write n into Rn, then read it back.
    for (int n = 0; n < 8; n++) begin
      data_in  = 16'(n);
      writenum = 3'(n);
      write    = 1'b1;
      tick();
      write   = 1'b0;
      readnum = 3'(n);
      #1;
      check($sformatf("wr_read%0d", n), data_out, 16'(n));
      check($sformatf("wr_R%0d", n), probe(n), 16'(n));
    end

    // With write low nothing may change.
    data_in = 16'hABCD;
    write   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      writenum = 3'(k * 2);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      readnum = 3'(i);
      #1;
      check($sformatf("nowr_read%0d", i), data_out, 16'(i));
    end

    // Only R5 changes.
    data_in  = 16'h1234;
    writenum = 3'd5;
    write    = 1'b1;
    tick();
    write = 1'b0;
    check_all_regs("iso");
    check("iso_R5_abs", probe(5), 16'h1234);
    check("iso_R4_abs", probe(4), 16'h0004);
    check("iso_R6_abs", probe(6), 16'h0006);

    // Reset beats a simultaneous write.
    rst_n    = 1'b0;
    write    = 1'b1;
    writenum = 3'd2;
    data_in  = 16'hFFFF;
    tick();
    rst_n = 1'b1;
    write = 1'b0;
    check("rst_vs_wr_R2", probe(2), 16'h0000);
    check_all_regs("rst_vs_wr");

    // Same-index read and write.
    data_in  = 16'h5A5A;
    writenum = 3'd3;
    write    = 1'b1;
    tick();
    readnum  = 3'd3;
    data_in  = 16'h00AA;
    writenum = 3'd3;
    write    = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_idx_before", data_out, 16'h00AA);
`else
    check("same_idx_before", data_out, 16'h5A5A);
`endif
    tick();
    write = 1'b0;
    #1;
    check("same_idx_after", data_out, 16'h00AA);

    // Random traffic with occasional resets.
    for (int it = 0; it < 300; it++) begin
      rst_n    = ($urandom_range(0, 15) != 0);
      write    = $urandom_range(0, 1) == 1;
      writenum = 3'($urandom_range(0, 7));
      readnum  = ($urandom_range(0, 3) == 0) ? writenum : 3'($urandom_range(0, 7));
      data_in  = 16'($urandom);
      #1;
      check($sformatf("rnd%0d_pre", it), data_out, expect_read());
      tick();
      rst_n = 1'b1;
      write = 1'b0;
      #1;
      check($sformatf("rnd%0d_post", it), data_out, model[readnum]);
      check($sformatf("rnd%0d_probe", it), probe(it % 8), model[it % 8]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile
